// File: rtl/otter_fetch_stage.sv
// OTTER instruction-fetch stage: PC register, redirect select, single-outstanding
// instruction-memory fetch, IF/ID register backed by a one-entry skid buffer.
//   state | meaning
//   ISSUE | may issue a fetch at pc (blocked while the skid is full or redirecting)
//   WAIT  | fetch in flight, returned word will be delivered
//   DROP  | wrong-path fetch in flight, returned word will be discarded
module otter_fetch_stage #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  PC_SOURCE,
  input  logic [31:0] JALR_TGT,
  input  logic [31:0] BRANCH_TGT,
  input  logic [31:0] JAL_TGT,
  input  logic [31:0] MTVEC,
  input  logic [31:0] MEPC,
  input  logic        STALL,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        IF_VALID,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_INSTR
);

  localparam logic [1:0] ST_ISSUE = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic        deliver;

  always_comb begin
    redirect   = 1'b0;
    target_raw = pc;
    case (PC_SOURCE)
      3'd1:    begin redirect = 1'b1; target_raw = JALR_TGT;   end
      3'd2:    begin redirect = 1'b1; target_raw = BRANCH_TGT; end
      3'd3:    begin redirect = 1'b1; target_raw = JAL_TGT;    end
      3'd4:    begin redirect = 1'b1; target_raw = MTVEC;      end
      3'd5:    begin redirect = 1'b1; target_raw = MEPC;       end
      default: begin redirect = 1'b0; target_raw = pc;         end
    endcase
    target = {target_raw[31:2], 2'b00};
  end

  // Holding off requests while the skid is full keeps delivery and skid load exclusive.
  assign IMEM_REQ  = !RST && (state == ST_ISSUE) && !skid_valid && !redirect;
  assign IMEM_ADDR = pc;
  assign deliver   = (state == ST_WAIT) && IMEM_RVALID && !redirect;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_ISSUE;
      pc         <= RESET_VEC;
      req_pc     <= RESET_VEC;
      skid_valid <= 1'b0;
      skid_pc    <= 32'h0;
      skid_instr <= NOP_INSTR;
      IF_VALID   <= 1'b0;
      IF_PC      <= 32'h0;
      IF_INSTR   <= NOP_INSTR;
    end else if (redirect) begin
      pc         <= target;
      IF_VALID   <= 1'b0;
      IF_INSTR   <= NOP_INSTR;
      skid_valid <= 1'b0;
      if (state != ST_ISSUE)
        state <= IMEM_RVALID ? ST_ISSUE : ST_DROP;
    end else begin
      case (state)
        ST_ISSUE: if (IMEM_REQ) begin
          req_pc <= pc;
          pc     <= pc + 32'd4;
          state  <= ST_WAIT;
        end
        ST_WAIT:  if (IMEM_RVALID) state <= ST_ISSUE;
        ST_DROP:  if (IMEM_RVALID) state <= ST_ISSUE;
        default:  state <= ST_ISSUE;
      endcase

      if (deliver) begin
        if (!IF_VALID || !STALL) begin
          IF_VALID <= 1'b1;
          IF_PC    <= req_pc;
          IF_INSTR <= IMEM_RDATA;
        end else begin
          skid_valid <= 1'b1;
          skid_pc    <= req_pc;
          skid_instr <= IMEM_RDATA;
        end
      end else if (IF_VALID && !STALL) begin
        if (skid_valid) begin
          IF_PC      <= skid_pc;
          IF_INSTR   <= skid_instr;
          skid_valid <= 1'b0;
        end else begin
          IF_VALID <= 1'b0;
          IF_INSTR <= NOP_INSTR;
        end
      end
    end
  end

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Bench for otter_fetch_stage: queue-based fetch model, variable-latency memory,
// directed redirect/stall/reset scenarios with literal expectations.
module tb_otter_fetch_stage;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  PC_SOURCE;
  logic [31:0] JALR_TGT, BRANCH_TGT, JAL_TGT, MTVEC, MEPC;
  logic        STALL;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic        IF_VALID;
  logic [31:0] IF_PC, IF_INSTR;

  otter_fetch_stage #(.RESET_VEC(RESET_VEC), .NOP_INSTR(NOP_INSTR)) dut (
    .CLK(CLK), .RST(RST), .PC_SOURCE(PC_SOURCE),
    .JALR_TGT(JALR_TGT), .BRANCH_TGT(BRANCH_TGT), .JAL_TGT(JAL_TGT),
    .MTVEC(MTVEC), .MEPC(MEPC), .STALL(STALL),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .IF_VALID(IF_VALID), .IF_PC(IF_PC), .IF_INSTR(IF_INSTR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // Model: fetched words waiting for decode (head = IF/ID), plus the in-flight fetch.
  entry_t      m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_fly_addr;
  bit          m_fly;
  bit          m_stale;

  // Memory: one outstanding request, answers `lat` cycles after the request.
  int          lat;
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;

  logic [31:0] req_log[$];
  logic [31:0] acc_log[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'd7) ^ 32'h5A00_0003;
  endfunction

  function automatic bit is_redirect(input logic [2:0] ps);
    return (ps >= 3'd1) && (ps <= 3'd5);
  endfunction

  function automatic logic [31:0] target_of(input logic [2:0] ps);
    logic [31:0] t;
    case (ps)
      3'd1:    t = JALR_TGT;
      3'd2:    t = BRANCH_TGT;
      3'd3:    t = JAL_TGT;
      3'd4:    t = MTVEC;
      3'd5:    t = MEPC;
      default: t = m_pc;
    endcase
    return {t[31:2], 2'b00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int which, input int idx);
    if (which == 0) return (idx < req_log.size()) ? req_log[idx] : 32'hBAD0_BAD0;
    return (idx < acc_log.size()) ? acc_log[idx] : 32'hBAD0_BAD0;
  endfunction

  task automatic step();
    bit          rv;
    logic [31:0] rd;
    bit          redir;
    bit          exp_req;
    bit          req_s;
    logic [31:0] addr_s;
    bit          deliver;
    @(negedge CLK);
    rv = mem_busy && (mem_cnt <= 1);
    rd = rv ? word_at(mem_addr) : 32'hDEAD_BEEF;
    IMEM_RVALID = rv;
    IMEM_RDATA  = rd;
    #1;
    redir   = is_redirect(PC_SOURCE);
    exp_req = !RST && !m_fly && (m_q.size() < 2) && !redir;
    chk("imem_req", 32'(IMEM_REQ), 32'(exp_req));
    if (exp_req) chk("imem_addr", IMEM_ADDR, m_pc);
    chk("if_valid", 32'(IF_VALID), 32'(m_q.size() > 0));
    chk("if_instr", IF_INSTR, (m_q.size() > 0) ? m_q[0].instr : NOP_INSTR);
    if (m_q.size() > 0) chk("if_pc", IF_PC, m_q[0].pc);
    req_s  = IMEM_REQ;
    addr_s = IMEM_ADDR;
    if (req_s) req_log.push_back(addr_s);
    if (IF_VALID && !STALL) acc_log.push_back(IF_PC);
    @(posedge CLK);
    if (RST) begin
      m_q.delete();
      m_pc     = RESET_VEC;
      m_fly    = 1'b0;
      m_stale  = 1'b0;
      mem_busy = 1'b0;
    end else begin
      if (redir) begin
        m_q.delete();
        if (m_fly) begin
          if (rv) m_fly = 1'b0;
          else    m_stale = 1'b1;
        end
        m_pc = target_of(PC_SOURCE);
      end else begin
        deliver = m_fly && rv && !m_stale;
        if (m_fly && rv) m_fly = 1'b0;
        if ((m_q.size() > 0) && !STALL) void'(m_q.pop_front());
        if (deliver) m_q.push_back(entry_t'{pc: m_fly_addr, instr: rd});
        if (exp_req) begin
          m_fly      = 1'b1;
          m_stale    = 1'b0;
          m_fly_addr = m_pc;
          m_pc       = m_pc + 32'd4;
        end
      end
      if (rv) mem_busy = 1'b0;
      else if (mem_busy) mem_cnt--;
      if (req_s) begin
        mem_busy = 1'b1;
        mem_cnt  = lat;
        mem_addr = addr_s;
      end
    end
    #1;
  endtask

  task automatic run_until_req(input int budget);
    int n0;
    n0 = req_log.size();
    for (int i = 0; i < budget && req_log.size() == n0; i++) step();
    checks++;
    if (req_log.size() == n0) begin
      failures++;
      $display("FAIL wait_req timeout actual=no_request required=request");
    end
  endtask

  int nreq, nacc;

  initial begin
    RST = 1'b1; PC_SOURCE = 3'd0; STALL = 1'b0;
    JALR_TGT = '0; BRANCH_TGT = '0; JAL_TGT = '0; MTVEC = '0; MEPC = '0;
    IMEM_RVALID = 1'b0; IMEM_RDATA = '0;
    lat = 1; mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0;
    m_pc = RESET_VEC; m_fly = 1'b0; m_stale = 1'b0; m_fly_addr = '0;
    @(posedge CLK); #1;
    step(); step();
    chk("reset_if_valid", 32'(IF_VALID), 32'h0);
    chk("reset_if_pc", IF_PC, 32'h0);
    chk("reset_if_instr", IF_INSTR, 32'h13);
    chk("reset_req_low", 32'(IMEM_REQ), 32'h0);
    chk("reset_addr", IMEM_ADDR, 32'h0);
    RST = 1'b0;

    // Sequential fetch, 1-cycle memory
    repeat (6) step();
    chk("seq_req0", log_at(0, 0), 32'h0);
    chk("seq_req1", log_at(0, 1), 32'h4);
    chk("seq_req2", log_at(0, 2), 32'h8);
    chk("seq_acc0", log_at(1, 0), 32'h0);
    chk("seq_acc1", log_at(1, 1), 32'h4);

    // Stall with IF/ID at 0x8: skid catches 0xC, no further requests
    STALL = 1'b1;
    repeat (6) step();
    chk("stall_if_valid", 32'(IF_VALID), 32'h1);
    chk("stall_if_pc", IF_PC, 32'h8);
    chk("stall_no_req", 32'(IMEM_REQ), 32'h0);
    chk("stall_req_count", 32'(req_log.size()), 32'd4);
    chk("stall_req3", log_at(0, 3), 32'hC);
    STALL = 1'b0;
    repeat (3) step();
    chk("release_acc8", log_at(1, 2), 32'h8);
    chk("release_accC", log_at(1, 3), 32'hC);

    // Branch while a 3-cycle fetch is in flight
    lat = 3;
    run_until_req(10);
    PC_SOURCE = 3'd2; BRANCH_TGT = 32'h100;
    step();
    PC_SOURCE = 3'd0;
    nreq = req_log.size(); nacc = acc_log.size();
    run_until_req(10);
    chk("branch_next_req", log_at(0, nreq), 32'h100);
    repeat (8) step();
    chk("branch_first_acc", log_at(1, nacc), 32'h100);

    // JALR with stall and both buffer entries full
    lat = 1; STALL = 1'b1;
    repeat (12) step();
    PC_SOURCE = 3'd1; JALR_TGT = 32'h203;
    step();
    PC_SOURCE = 3'd0;
    #1;
    chk("jalr_flush_valid", 32'(IF_VALID), 32'h0);
    chk("jalr_flush_instr", IF_INSTR, 32'h13);
    chk("jalr_req", 32'(IMEM_REQ), 32'h1);
    chk("jalr_addr", IMEM_ADDR, 32'h200);
    STALL = 1'b0;
    repeat (4) step();

    // JAL into DROP, then trap and MRET back to back; only MEPC is fetched
    lat = 4;
    run_until_req(10);
    PC_SOURCE = 3'd3; JAL_TGT = 32'h300; step();
    PC_SOURCE = 3'd4; MTVEC = 32'h80;    step();
    PC_SOURCE = 3'd5; MEPC = 32'h44;     step();
    PC_SOURCE = 3'd6; JAL_TGT = 32'h900; MTVEC = 32'h980; MEPC = 32'h9C0;
    nreq = req_log.size();
    repeat (14) step();
    chk("mret_req", log_at(0, nreq), 32'h44);
    chk("src6_seq_req", log_at(0, nreq + 1), 32'h48);

    // Reset mid-WAIT
    lat = 3; PC_SOURCE = 3'd7;
    run_until_req(10);
    step();
    RST = 1'b1;
    step();
    chk("rst_wait_valid", 32'(IF_VALID), 32'h0);
    chk("rst_wait_instr", IF_INSTR, 32'h13);
    chk("rst_wait_addr", IMEM_ADDR, RESET_VEC);
    RST = 1'b0;
    #1;
    chk("rst_release_req", 32'(IMEM_REQ), 32'h1);

    // PC wrap at the top of the address space
    lat = 1; PC_SOURCE = 3'd3; JAL_TGT = 32'hFFFF_FFFC;
    step();
    PC_SOURCE = 3'd7;
    nreq = req_log.size(); nacc = acc_log.size();
    repeat (6) step();
    chk("wrap_req_top", log_at(0, nreq), 32'hFFFF_FFFC);
    chk("wrap_req_zero", log_at(0, nreq + 1), 32'h0);
    chk("wrap_acc_top", log_at(1, nacc), 32'hFFFF_FFFC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
